// File: rtl/flb_sync_sd.sv
// FLB sync stage: samples ref_clk as data, captures the DLF word/band at programmable lags after each ref
// edge, and splits the word into a matrix code plus a 1st-order sigma-delta bitstream of the fraction.
module flb_sync_sd #(
   parameter int DLF_W   = 16,
   parameter int MTRX_W  = 8,
   parameter int BAND_W  = 8,
   parameter int OS_W    = 8,
   parameter int LAG_W   = 2,
   parameter int DEC_DIV = 8
) (
   input  logic              nsh_clk,
   input  logic              nsh_rst,
   input  logic              ref_clk,
   input  logic [DLF_W-1:0]  dlf_out,
   input  logic [BAND_W-1:0] band,
   input  logic              csr_sync_en,
   input  logic              csr_sd_mode,
   input  logic [LAG_W-1:0]  csr_flb_smpl_clk_lag,
   input  logic [LAG_W-1:0]  csr_flb_mtrx_clk_lag,
   output logic [MTRX_W-1:0] s_mtrx,
   output logic [BAND_W-1:0] s_band,
   output logic [OS_W-1:0]   s_os,
   output logic              dec_clk
);

   localparam int FRAC_W = DLF_W - MTRX_W;
   localparam int DEC_CW = $clog2(DEC_DIV);

   logic               clr;
   logic [2:0]         sync_q;
   logic               ref_evt;
   logic [LAG_W-1:0]   lag_sel [2];
   logic [LAG_W-1:0]   lag_cnt_q [2];
   logic               lag_pend_q [2];
   logic               stb [2];
   logic               smpl_stb;
   logic               mtrx_stb;
   logic [DLF_W-1:0]   dlf_q;
   logic [BAND_W-1:0]  band_q;
   logic [MTRX_W-1:0]  s_mtrx_q;
   logic [BAND_W-1:0]  s_band_q;
   logic [OS_W-1:0]    s_os_q;
   logic               dec_clk_q;
   logic [FRAC_W-1:0]  frac_q;
   logic [FRAC_W-1:0]  acc_q;
   logic [DEC_CW-1:0]  dec_cnt_q;
   logic [DEC_CW-1:0]  dec_cnt_d;
   logic               tick;
   logic [FRAC_W:0]    sum;
   logic               carry;

   // Disabling the block is treated exactly like reset so re-enable needs a fresh ref edge.
   assign clr     = nsh_rst | ~csr_sync_en;
   assign ref_evt = sync_q[1] & ~sync_q[2];

   assign lag_sel[0] = csr_flb_smpl_clk_lag;
   assign lag_sel[1] = csr_flb_mtrx_clk_lag;

   // Index 0 is the sample-lag counter, index 1 the matrix-update counter.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lag
      assign stb[gi] = ref_evt ? (lag_sel[gi] == '0)
                               : (lag_pend_q[gi] && lag_cnt_q[gi] == LAG_W'(1));

      always_ff @(posedge nsh_clk) begin
         if (clr) begin
            lag_cnt_q[gi]  <= '0;
            lag_pend_q[gi] <= 1'b0;
         end else if (ref_evt) begin
            lag_cnt_q[gi]  <= lag_sel[gi];
            lag_pend_q[gi] <= (lag_sel[gi] != '0);
         end else if (lag_pend_q[gi]) begin
            lag_cnt_q[gi] <= lag_cnt_q[gi] - LAG_W'(1);
            if (lag_cnt_q[gi] == LAG_W'(1)) begin
               lag_pend_q[gi] <= 1'b0;
            end
         end
      end
   end

   assign smpl_stb = stb[0];
   assign mtrx_stb = stb[1];

   always_comb begin
      tick  = ~mtrx_stb && (dec_cnt_q == DEC_CW'(DEC_DIV - 1));
      sum   = {1'b0, acc_q} + {1'b0, frac_q};
      carry = sum[FRAC_W] & csr_sd_mode;
      if (mtrx_stb || dec_cnt_q == DEC_CW'(DEC_DIV - 1)) begin
         dec_cnt_d = '0;
      end else begin
         dec_cnt_d = dec_cnt_q + DEC_CW'(1);
      end
   end

   always_ff @(posedge nsh_clk) begin
      if (clr) begin
         sync_q    <= '0;
         dlf_q     <= '0;
         band_q    <= '0;
         s_mtrx_q  <= '0;
         s_band_q  <= '0;
         s_os_q    <= '0;
         frac_q    <= '0;
         acc_q     <= '0;
         dec_cnt_q <= '0;
         dec_clk_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[1:0], ref_clk};
         dec_cnt_q <= dec_cnt_d;
         dec_clk_q <= (dec_cnt_d >= DEC_CW'(DEC_DIV / 2));
         if (smpl_stb) begin
            dlf_q  <= dlf_out;
            band_q <= band;
         end
         // Matrix update publishes the registered capture; a band change restarts the modulator.
         if (mtrx_stb) begin
            s_mtrx_q <= dlf_q[DLF_W-1 -: MTRX_W];
            frac_q   <= dlf_q[FRAC_W-1:0];
            s_band_q <= band_q;
            if (band_q != s_band_q) begin
               acc_q  <= '0;
               s_os_q <= '0;
            end
         end else if (tick) begin
            if (csr_sd_mode) begin
               acc_q <= sum[FRAC_W-1:0];
            end
            s_os_q <= {s_os_q[OS_W-2:0], carry};
         end
      end
   end

   assign s_mtrx  = s_mtrx_q;
   assign s_band  = s_band_q;
   assign s_os    = s_os_q;
   assign dec_clk = dec_clk_q;

endmodule

// File: tb/tb_flb_sync_sd.sv
// Scoreboard bench for flb_sync_sd: an event-level reference model predicts every cycle's outputs,
// a monitor compares them on the falling edge; a few directed checks cover the named scenarios.
module tb_flb_sync_sd;

   localparam int DLF_W = 16, MTRX_W = 8, BAND_W = 8, OS_W = 8, LAG_W = 2, DEC_DIV = 8;
   localparam int FRAC_W = DLF_W - MTRX_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ref_clk = 1'b0;
   logic [DLF_W-1:0]  dlf_out = '0;
   logic [BAND_W-1:0] band = '0;
   logic              en = 1'b0;
   logic              mode = 1'b0;
   logic [LAG_W-1:0]  lag_s = '0;
   logic [LAG_W-1:0]  lag_m = '0;
   logic [MTRX_W-1:0] s_mtrx;
   logic [BAND_W-1:0] s_band;
   logic [OS_W-1:0]   s_os;
   logic              dec_clk;

   flb_sync_sd #(.DLF_W(DLF_W), .MTRX_W(MTRX_W), .BAND_W(BAND_W), .OS_W(OS_W),
                 .LAG_W(LAG_W), .DEC_DIV(DEC_DIV)) dut (
      .nsh_clk(clk), .nsh_rst(rst), .ref_clk(ref_clk), .dlf_out(dlf_out), .band(band),
      .csr_sync_en(en), .csr_sd_mode(mode), .csr_flb_smpl_clk_lag(lag_s),
      .csr_flb_mtrx_clk_lag(lag_m), .s_mtrx(s_mtrx), .s_band(s_band), .s_os(s_os),
      .dec_clk(dec_clk)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] m;
      logic [7:0] b;
      logic [7:0] os;
      logic       dc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: ref sample history, absolute strobe due-cycles, dec phase origin.
   int t = 0, o = 0, sdue = -1, mdue = -1;
   int h1 = 0, h2 = 0, h3 = 0;
   int dlfq = 0, bandq = 0, smtrx = 0, sband = 0, frac = 0, acc = 0, os = 0, dec = 0;

   task automatic model_step();
      int evt, ss, ms, tick, carry, sum;
      exp_t e;
      t++;
      if (rst || !en) begin
         h1 = 0; h2 = 0; h3 = 0; sdue = -1; mdue = -1;
         dlfq = 0; bandq = 0; smtrx = 0; sband = 0; frac = 0; acc = 0; os = 0; dec = 0;
         o = t;
      end else begin
         evt = (h2 == 1 && h3 == 0) ? 1 : 0;
         if (evt != 0) begin
            sdue = t + int'(lag_s);
            mdue = t + int'(lag_m);
         end
         ss   = (sdue == t) ? 1 : 0;
         ms   = (mdue == t) ? 1 : 0;
         tick = (ms == 0 && ((t - 1 - o) % DEC_DIV) == DEC_DIV - 1) ? 1 : 0;
         if (ms != 0) begin
            smtrx = dlfq / (2 ** FRAC_W);
            frac  = dlfq % (2 ** FRAC_W);
            if (bandq != sband) begin
               acc = 0;
               os  = 0;
            end
            sband = bandq;
            o = t;
         end else if (tick != 0) begin
            carry = 0;
            if (mode) begin
               sum   = acc + frac;
               carry = (sum >= 2 ** FRAC_W) ? 1 : 0;
               acc   = sum % (2 ** FRAC_W);
            end
            os = (os * 2 + carry) % (2 ** OS_W);
         end
         if (ss != 0) begin
            dlfq  = int'(dlf_out);
            bandq = int'(band);
         end
         dec = (((t - o) % DEC_DIV) >= DEC_DIV / 2) ? 1 : 0;
         h3 = h2; h2 = h1; h1 = int'(ref_clk);
      end
      e.m  = 8'(smtrx);
      e.b  = 8'(sband);
      e.os = 8'(os);
      e.dc = (dec != 0);
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: every registered output set is compared against the model's prediction for that edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (s_mtrx !== e.m || s_band !== e.b || s_os !== e.os || dec_clk !== e.dc) begin
               errors++;
               $display("FAIL scoreboard t=%0d: got mtrx=%h band=%h os=%h dec=%b, want mtrx=%h band=%h os=%h dec=%b",
                        $time, s_mtrx, s_band, s_os, dec_clk, e.m, e.b, e.os, e.dc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic ref_pulse(input logic [15:0] d, input logic [7:0] b, input int hi, input int lo);
      dlf_out = d;
      band    = b;
      ref_clk = 1'b1;
      repeat (hi) @(negedge clk);
      ref_clk = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] bands [4];
      bands[0] = 8'h00; bands[1] = 8'h3C; bands[2] = 8'hFF; bands[3] = 8'hAA;

      // Reset with ref toggling and an all-ones word.
      dlf_out = 16'hFFFF;
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         ref_clk = ~ref_clk;
         @(negedge clk);
      end
      chk("reset_mtrx", 32'(s_mtrx), 32'h0);
      chk("reset_os", 32'(s_os), 32'h0);
      chk("reset_dec", 32'(dec_clk), 32'h0);
      ref_clk = 1'b0;
      rst = 1'b0;
      en  = 1'b1;
      mode = 1'b1;

      // Lag: capture at +2, publish at +1, so the second event publishes the first word.
      lag_s = 2'd2; lag_m = 2'd1;
      ref_pulse(16'h1234, 8'h01, 10, 10);
      chk("lag_first_publish", 32'(s_mtrx), 32'h0);
      ref_pulse(16'h5678, 8'h01, 10, 10);
      chk("lag_second_publish", 32'(s_mtrx), 32'h12);
      chk("lag_band", 32'(s_band), 32'h01);

      // Sigma-delta with a quarter fraction.
      lag_s = 2'd0; lag_m = 2'd1;
      for (int i = 0; i < 6; i++) ref_pulse(16'h8040, 8'h01, 20, 20);
      chk("sd_mtrx", 32'(s_mtrx), 32'h80);
      chk("sd_popcount", 32'($countones(s_os)), 32'd2);

      // Truncate mode drains the window to zero.
      mode = 1'b0;
      for (int i = 0; i < 3; i++) ref_pulse(16'h8040, 8'h01, 20, 20);
      chk("trunc_os", 32'(s_os), 32'h0);
      chk("trunc_mtrx", 32'(s_mtrx), 32'h80);

      // Band changes restart the modulator.
      mode = 1'b1;
      ref_pulse(16'h8040, 8'h00, 20, 20);
      ref_pulse(16'h8040, 8'hFF, 20, 20);
      chk("band_ff", 32'(s_band), 32'hFF);
      ref_pulse(16'h8040, 8'hAA, 20, 20);
      chk("band_aa", 32'(s_band), 32'hAA);

      // Enable drop mid-period.
      ref_clk = 1'b1;
      repeat (5) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("en_drop_mtrx", 32'(s_mtrx), 32'h0);
      chk("en_drop_band", 32'(s_band), 32'h0);
      ref_clk = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b1;

      // Ref period of three cycles with lag three: every strobe is restarted before it fires.
      lag_s = 2'd3; lag_m = 2'd3;
      for (int i = 0; i < 12; i++) ref_pulse(16'h9999, 8'h55, 1, 2);
      chk("overlap_mtrx", 32'(s_mtrx), 32'h0);

      // Randomized operation.
      for (int i = 0; i < 300; i++) begin
         if (i % 10 == 0) begin
            lag_s = LAG_W'($urandom_range(0, 3));
            lag_m = LAG_W'($urandom_range(0, 3));
            mode  = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 40) == 0) en = 1'b0;
         else en = 1'b1;
         ref_pulse(16'($urandom), bands[$urandom_range(0, 3)],
                   $urandom_range(1, 15), $urandom_range(1, 15));
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
